dest_reg_scoreboard: RTL and testbench

//  Consumes the write-register number chosen by the EX-stage destination mux (rt vs rd)
//  and tracks it through the EX/MEM and MEM/WB slots.

---
 rtl/dest_reg_scoreboard_if.sv | 52 +++++
 rtl/dest_reg_scoreboard.sv | 94 +++++++++
 tb/tb_dest_reg_scoreboard.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dest_reg_scoreboard_if.sv
// Hazard-unit bundle: EX/ID register numbers in, forwarding selects and write-back port out.
// stall_count is present only when STALL_CNT_EN is defined.
interface dest_reg_scoreboard_if #(
    parameter int REG_ADDR_W = 5
`ifdef STALL_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  flush;
    logic                  freeze;
    logic                  stall_id;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_we;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0]      stall_count;

    modport slave (
        input  ex_dest, ex_regwrite, ex_memread, ex_rs, ex_rt,
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, flush, freeze,
        output stall_id, fwd_a, fwd_b, wb_dest, wb_we, stall_count
    );

    modport master (
        output ex_dest, ex_regwrite, ex_memread, ex_rs, ex_rt,
        output id_rs, id_rt, id_uses_rs, id_uses_rt, flush, freeze,
        input  stall_id, fwd_a, fwd_b, wb_dest, wb_we, stall_count
    );
`else
    modport slave (
        input  ex_dest, ex_regwrite, ex_memread, ex_rs, ex_rt,
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, flush, freeze,
        output stall_id, fwd_a, fwd_b, wb_dest, wb_we
    );

    modport master (
        output ex_dest, ex_regwrite, ex_memread, ex_rs, ex_rt,
        output id_rs, id_rt, id_uses_rs, id_uses_rt, flush, freeze,
        input  stall_id, fwd_a, fwd_b, wb_dest, wb_we
    );
`endif
endinterface

// File: rtl/dest_reg_scoreboard.sv
// Tracks the EX destination register through MEM/WB slots to drive load-use stall, EX forwarding
// and the register-file write port. Define STALL_CNT_EN to add a saturating stall counter.
module dest_reg_scoreboard #(
    parameter int REG_ADDR_W = 5
`ifdef STALL_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input logic                  Clk,
    input logic                  Reset_n,
    dest_reg_scoreboard_if.slave bus
);
    logic                  r_memValid;
    logic                  r_memRegwrite;
    logic                  r_memMemread;
    logic [REG_ADDR_W-1:0] r_memDest;
    logic                  r_wbWr;
    logic [REG_ADDR_W-1:0] r_wbDest;

    logic                  w_memWr;
    logic                  w_rsHit;
    logic                  w_rtHit;
    logic                  w_stall;
    logic [1:0]            w_fwdA;
    logic [1:0]            w_fwdB;

    assign w_memWr = r_memValid & r_memRegwrite & (r_memDest != '0);

    // WB keeps the already-qualified write flag so wb_we comes straight off a flop.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_memValid    <= 1'b0;
            r_memRegwrite <= 1'b0;
            r_memMemread  <= 1'b0;
            r_memDest     <= '0;
            r_wbWr        <= 1'b0;
            r_wbDest      <= '0;
        end else if (!bus.freeze) begin
            r_memValid    <= ~bus.flush;
            r_memRegwrite <= bus.ex_regwrite;
            r_memMemread  <= bus.ex_memread;
            r_memDest     <= bus.ex_dest;
            r_wbWr        <= w_memWr;
            r_wbDest      <= r_memDest;
        end
    end

    // A load still in MEM has no data yet; the stall guarantees it is consumed from WB.
    always_comb begin
        w_fwdA = 2'b00;
        if (Reset_n) begin
            if (w_memWr && !r_memMemread && (r_memDest == bus.ex_rs))
                w_fwdA = 2'b10;
            else if (r_wbWr && (r_wbDest == bus.ex_rs))
                w_fwdA = 2'b01;
        end
    end

    always_comb begin
        w_fwdB = 2'b00;
        if (Reset_n) begin
            if (w_memWr && !r_memMemread && (r_memDest == bus.ex_rt))
                w_fwdB = 2'b10;
            else if (r_wbWr && (r_wbDest == bus.ex_rt))
                w_fwdB = 2'b01;
        end
    end

    assign w_rsHit = bus.id_uses_rs & (bus.id_rs == bus.ex_dest);
    assign w_rtHit = bus.id_uses_rt & (bus.id_rt == bus.ex_dest);

    // A squashed load cannot cause a stall, so flush masks the hazard.
    assign w_stall = Reset_n & ~bus.flush & bus.ex_regwrite & bus.ex_memread
                   & (bus.ex_dest != '0) & (w_rsHit | w_rtHit);

    assign bus.stall_id = w_stall;
    assign bus.fwd_a    = w_fwdA;
    assign bus.fwd_b    = w_fwdB;
    assign bus.wb_we    = r_wbWr;
    assign bus.wb_dest  = r_wbDest;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stallCount;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_stallCount <= '0;
        else if (w_stall && !bus.freeze && (r_stallCount != '1))
            r_stallCount <= r_stallCount + 1'b1;
    end

    assign bus.stall_count = r_stallCount;
`endif
endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Randomised scoreboard bench: a pipeline-history model predicts each cycle's outputs into a queue
// that a negedge monitor pops and compares against the DUT.
module tb_dest_reg_scoreboard;
    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       mr;
        logic [4:0] dest;
    } rec_t;

    typedef struct packed {
        logic        stall;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [4:0]  wd;
        logic        we;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    rec_t        pipe[$];
    exp_t        expQ[$];
    logic [31:0] refCnt = 32'd0;
    int          total = 0;
    int          bad = 0;

    dest_reg_scoreboard_if #(.REG_ADDR_W(5)) bus ();

    dest_reg_scoreboard #(.REG_ADDR_W(5)) dut (
        .Clk     (clk),
        .Reset_n (rstN),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Index 0 of the history is the most recent accepted EX instruction (MEM), index 1 the one before (WB).
    function automatic void clearPipe();
        rec_t z;
        z = '0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
    endfunction

    function automatic logic writes(input rec_t r);
        return r.valid && r.rw && (r.dest != 5'd0);
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] src);
        if (writes(pipe[0]) && !pipe[0].mr && pipe[0].dest == src) return 2'b10;
        if (writes(pipe[1]) && pipe[1].dest == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic refStall();
        logic hit;
        hit = (bus.id_uses_rs && bus.id_rs == bus.ex_dest) || (bus.id_uses_rt && bus.id_rt == bus.ex_dest);
        return rstN && !bus.flush && bus.ex_regwrite && bus.ex_memread && (bus.ex_dest != 5'd0) && hit;
    endfunction

    always @(posedge clk or negedge rstN) begin
        rec_t r;
        if (!rstN) begin
            clearPipe();
            refCnt <= 32'd0;
        end else if (!bus.freeze) begin
            if (refStall() && refCnt != 32'hFFFF_FFFF) refCnt <= refCnt + 32'd1;
            r.valid = !bus.flush;
            r.rw    = bus.ex_regwrite;
            r.mr    = bus.ex_memread;
            r.dest  = bus.ex_dest;
            pipe.push_front(r);
            void'(pipe.pop_back());
        end
    end

    task automatic pushExpected();
        exp_t e;
        e = '0;
        if (rstN) begin
            e.stall = refStall();
            e.fa    = refFwd(bus.ex_rs);
            e.fb    = refFwd(bus.ex_rt);
            e.wd    = pipe[1].dest;
            e.we    = writes(pipe[1]);
            e.cnt   = refCnt;
        end
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [4:0] dest, input logic rw, input logic mr,
                                 input logic [4:0] ers, input logic [4:0] ert,
                                 input logic [4:0] irs, input logic [4:0] irt,
                                 input logic urs, input logic urt, input logic fl, input logic fz);
        @(posedge clk);
        #1;
        rstN            = 1'b1;
        bus.ex_dest     = dest;
        bus.ex_regwrite = rw;
        bus.ex_memread  = mr;
        bus.ex_rs       = ers;
        bus.ex_rt       = ert;
        bus.id_rs       = irs;
        bus.id_rt       = irt;
        bus.id_uses_rs  = urs;
        bus.id_uses_rt  = urt;
        bus.flush       = fl;
        bus.freeze      = fz;
        pushExpected();
    endtask

    task automatic assertReset(input int cycles);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        pushExpected();
        for (int i = 1; i < cycles; i++) begin
            @(posedge clk);
            #1;
            pushExpected();
        end
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("stall_id", int'(bus.stall_id), int'(e.stall));
            checkOutput("fwd_a", int'(bus.fwd_a), int'(e.fa));
            checkOutput("fwd_b", int'(bus.fwd_b), int'(e.fb));
            checkOutput("wb_we", int'(bus.wb_we), int'(e.we));
            checkOutput("wb_dest", int'(bus.wb_dest), int'(e.wd));
`ifdef STALL_CNT_EN
            checkOutput("stall_count", int'(bus.stall_count), int'(e.cnt));
`endif
        end
    end

    function automatic logic [4:0] rndReg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        clearPipe();
        bus.ex_dest = '0; bus.ex_regwrite = 0; bus.ex_memread = 0; bus.ex_rs = '0; bus.ex_rt = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.flush = 0; bus.freeze = 0;
        assertReset(2);

        // ALU chain on $8: MEM forward on rs, then WB forward on rt.
        applyStimulus(5'd8, 1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd12, 1, 0, 5'd8, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd13, 1, 0, 5'd0, 5'd8, 5'd0, 5'd0, 0, 0, 0, 0);

        // Load-use on $9: one stall, bubble, then dependent consumes from WB.
        applyStimulus(5'd9, 1, 1, 5'd0, 5'd0, 5'd1, 5'd9, 0, 1, 0, 0);
        applyStimulus(5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd14, 1, 0, 5'd1, 5'd9, 5'd0, 5'd0, 0, 0, 0, 0);

        // Zero register never forwards or writes.
        applyStimulus(5'd0, 1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);

        // Flushed $10 plus a squashed load-use match.
        applyStimulus(5'd10, 1, 1, 5'd0, 5'd0, 5'd10, 5'd0, 1, 0, 1, 0);
        applyStimulus(5'd0, 0, 0, 5'd10, 5'd10, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd0, 0, 0, 5'd10, 5'd10, 5'd0, 5'd0, 0, 0, 0, 0);

        // Freeze with $11 in MEM, then release.
        applyStimulus(5'd11, 1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(5'd7, 1, 1, 5'd11, 5'd0, 5'd7, 5'd0, 1, 0, 0, 1);
        applyStimulus(5'd0, 0, 0, 5'd11, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd0, 0, 0, 5'd11, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);

        // Reset with both slots valid and a live load-use pattern on the inputs.
        applyStimulus(5'd5, 1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd6, 1, 1, 5'd5, 5'd5, 5'd6, 5'd6, 1, 1, 0, 0);
        assertReset(2);
        applyStimulus(5'd0, 0, 0, 5'd5, 5'd6, 5'd0, 5'd0, 0, 0, 0, 0);
        applyStimulus(5'd0, 0, 0, 5'd5, 5'd6, 5'd0, 5'd0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0)
                assertReset(int'($urandom_range(1, 2)));
            else
                applyStimulus(rndReg(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                              rndReg(), rndReg(), rndReg(), rndReg(),
                              1'($urandom), 1'($urandom),
                              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain actual=%0d required=0 pending entries", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
